// File: rtl/mem_sdp_param.sv
// Simple-dual-port synchronous RAM with per-byte write enables, 1- or 2-cycle
// read latency, selectable read-during-write behaviour and an optional post-reset clear.
module mem_sdp_param #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o,
    output logic                busy_o
);
    localparam int                NBYTES    = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
        $error("mem_sdp_param: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("mem_sdp_param: DATA_W must be a multiple of 8");
    end

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;

    logic              wr_in_range_s;
    logic              wr_fire_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [NBYTES-1:0] mem_be_s;

    logic              rd_in_range_s;
    logic              rd_valid1_d;
    logic [DATA_W-1:0] rd_old_s;
    logic [DATA_W-1:0] rd_data1_d;
    logic              rd_valid1_q;
    logic [DATA_W-1:0] rd_data1_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear sequencer: after reset, walks every address once, then idles.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_q <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state_q <= ST_CLEAR;
                busy_q  <= 1'b1;
            end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    // Array write-port mux: the clear sequencer owns the port while busy.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_addr_i} < DEPTH_W);
        wr_fire_s     = wr_en_i && !busy_q && wr_in_range_s;
        if (busy_q) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = '0;
            mem_be_s    = '1;
        end else begin
            mem_we_s    = wr_fire_s;
            mem_waddr_s = wr_addr_i;
            mem_wdata_s = wr_data_i;
            mem_be_s    = wr_be_i;
        end
    end

    // Array storage; each byte lane updates only under its own enable.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[mem_waddr_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Read lookup; out-of-range or idle reads produce an all-zero word.
    always_comb begin
        rd_in_range_s = ({1'b0, rd_addr_i} < DEPTH_W);
        rd_valid1_d   = rd_en_i && !busy_q;
        rd_old_s      = '0;
        rd_data1_d    = '0;
        if (rd_valid1_d && rd_in_range_s) begin
            rd_old_s = mem_q[rd_addr_i];
            // Write-through forwards the merged word of a same-cycle write.
            if ((RDW_MODE == 1) && wr_fire_s && (wr_addr_i == rd_addr_i)) begin
                rd_data1_d = merge_bytes(rd_old_s, wr_data_i, wr_be_i);
            end else begin
                rd_data1_d = rd_old_s;
            end
        end else begin
            rd_data1_d = '0;
        end
    end

    // First read stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_valid1_d;
            rd_data1_q  <= rd_data1_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              rd_valid2_q;
        logic [DATA_W-1:0] rd_data2_q;

        // Second read stage, carrying the valid qualifier alongside the data.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid2_q <= 1'b0;
                rd_data2_q  <= '0;
            end else begin
                rd_valid2_q <= rd_valid1_q;
                rd_data2_q  <= rd_data1_q;
            end
        end

        assign rd_valid_o = rd_valid2_q;
        assign rd_data_o  = rd_data2_q;
    end else begin : g_lat1
        assign rd_valid_o = rd_valid1_q;
        assign rd_data_o  = rd_data1_q;
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_mem_sdp_param.sv
// Directed bench: four shared-stimulus instances covering latency, read-during-write
// mode, non-power-of-two depth and the no-clear variant.
module tb_mem_sdp_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [5:0]  rd_addr;

    logic [31:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
    logic        rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d;
    logic        busy_a, busy_b, busy_c, busy_d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_sdp_param #(.DATA_W(32), .DEPTH(64), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .busy_o(busy_a));

    mem_sdp_param #(.DATA_W(32), .DEPTH(64), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .busy_o(busy_b));

    mem_sdp_param #(.DATA_W(32), .DEPTH(48), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_c), .rd_valid_o(rd_valid_c), .busy_o(busy_c));

    mem_sdp_param #(.DATA_W(32), .DEPTH(64), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_d (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_d), .rd_valid_o(rd_valid_d), .busy_o(busy_d));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    task automatic set_rd(input logic en, input logic [5:0] a);
        rd_en   = en;
        rd_addr = a;
    endtask

    // Counts busy cycles of the 64- and 48-deep instances, bounded so a stuck busy still ends.
    task automatic wait_clear(output int n_a, output int n_c, output int n_v);
        n_a = 0;
        n_c = 0;
        n_v = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_a) break;
            n_a++;
            if (busy_c) n_c++;
            if (rd_valid_a || rd_valid_b) n_v++;
            step();
        end
    endtask

    initial begin
        int n_a, n_c, n_v, bad;
        logic [31:0] v5;
        logic        exp_v;
        logic [31:0] exp_d;

        reset = 1'b1;
        set_wr(1'b0, 6'd0, 32'h0, 4'h0);
        set_rd(1'b0, 6'd0);
        repeat (3) step();
        check_val("rst_busy_a", {31'd0, busy_a}, 32'd1);
        check_val("rst_busy_b", {31'd0, busy_b}, 32'd1);
        check_val("rst_busy_d", {31'd0, busy_d}, 32'd0);
        check_val("rst_valid_a", {31'd0, rd_valid_a}, 32'd0);
        check_val("rst_data_a", rd_data_a, 32'h0);
        check_val("rst_valid_b", {31'd0, rd_valid_b}, 32'd0);

        // Release reset with a write to 5 and a read held high through the clear.
        reset = 1'b0;
        set_wr(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
        set_rd(1'b1, 6'd5);
        wait_clear(n_a, n_c, n_v);
        set_wr(1'b0, 6'd0, 32'h0, 4'h0);
        set_rd(1'b0, 6'd0);
        check_val("clear_len_64", n_a, 32'd64);
        check_val("clear_len_48", n_c, 32'd48);
        check_val("busy_no_valid", n_v, 32'd0);

        bad = 0;
        v5  = 32'hFFFFFFFF;
        for (int a = 0; a < 64; a++) begin
            set_rd(1'b1, 6'(a));
            step();
            if (!rd_valid_a || (rd_data_a !== 32'h0)) bad++;
            if (a == 5) v5 = rd_data_a;
        end
        set_rd(1'b0, 6'd0);
        check_val("clear_all_zero", bad, 32'd0);
        check_val("busy_write_dropped", v5, 32'h0);
        step();
        check_val("idle_data_zero", rd_data_a, 32'h0);
        check_val("idle_valid_zero", {31'd0, rd_valid_a}, 32'd0);

        // Byte enables.
        set_wr(1'b1, 6'd3, 32'hAABBCCDD, 4'b1111);
        step();
        set_wr(1'b1, 6'd3, 32'h11223344, 4'b0101);
        step();
        set_wr(1'b0, 6'd0, 32'h0, 4'h0);
        set_rd(1'b1, 6'd3);
        step();
        set_rd(1'b0, 6'd0);
        check_val("be_merge_a", rd_data_a, 32'hAA22CC44);
        check_val("be_merge_c", rd_data_c, 32'hAA22CC44);
        step();
        check_val("be_merge_b", rd_data_b, 32'hAA22CC44);
        check_val("be_merge_d", rd_data_d, 32'hAA22CC44);
        check_val("lat1_return_zero", rd_data_a, 32'h0);

        // The no-clear instance was never busy, so it took the early write.
        set_rd(1'b1, 6'd5);
        step();
        set_rd(1'b0, 6'd0);
        step();
        check_val("noclear_write_d", rd_data_d, 32'hDEADBEEF);
        check_val("noclear_valid_d", {31'd0, rd_valid_d}, 32'd1);

        // Read-during-write.
        set_wr(1'b1, 6'd7, 32'h12345678, 4'hF);
        step();
        set_wr(1'b1, 6'd7, 32'hFFFFFFFF, 4'b0011);
        set_rd(1'b1, 6'd7);
        step();
        set_wr(1'b0, 6'd0, 32'h0, 4'h0);
        set_rd(1'b0, 6'd0);
        check_val("rdw_old_a", rd_data_a, 32'h12345678);
        step();
        check_val("rdw_through_b", rd_data_b, 32'h1234FFFF);
        check_val("rdw_old_d", rd_data_d, 32'h12345678);
        set_rd(1'b1, 6'd7);
        step();
        set_rd(1'b0, 6'd0);
        check_val("rdw_after_a", rd_data_a, 32'h1234FFFF);
        step();

        // Streaming reads on the 2-cycle instance.
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 6'(i), 32'hC0DE0000 + 32'(i), 4'hF);
            step();
        end
        set_wr(1'b0, 6'd0, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            set_rd(k < 4, 6'(k));
            step();
            exp_v = (k >= 1) && (k <= 4);
            exp_d = exp_v ? (32'hC0DE0000 + 32'(k - 1)) : 32'h0;
            check_val($sformatf("stream_valid_%0d", k), {31'd0, rd_valid_b}, {31'd0, exp_v});
            check_val($sformatf("stream_data_%0d", k), rd_data_b, exp_d);
        end

        // Depth 48: address 50 is out of range there.
        set_wr(1'b1, 6'd18, 32'h18181818, 4'hF);
        step();
        set_wr(1'b1, 6'd47, 32'h47474747, 4'hF);
        step();
        set_wr(1'b1, 6'd50, 32'hBAD0BAD0, 4'hF);
        step();
        set_wr(1'b0, 6'd0, 32'h0, 4'h0);
        set_rd(1'b1, 6'd18);
        step();
        check_val("oor_keep_18", rd_data_c, 32'h18181818);
        set_rd(1'b1, 6'd47);
        step();
        check_val("oor_keep_47", rd_data_c, 32'h47474747);
        set_rd(1'b1, 6'd50);
        step();
        set_rd(1'b0, 6'd0);
        check_val("oor_read_zero", rd_data_c, 32'h0);
        check_val("oor_read_valid", {31'd0, rd_valid_c}, 32'd1);
        check_val("inrange_50_a", rd_data_a, 32'hBAD0BAD0);
        step();

        // Reset at clear count 20 restarts the full sequence.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (20) step();
        check_val("midclear_busy", {31'd0, busy_a}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_clear(n_a, n_c, n_v);
        check_val("restart_len_64", n_a, 32'd64);

        // Reset with a 2-cycle read in flight.
        set_rd(1'b1, 6'd3);
        step();
        set_rd(1'b0, 6'd0);
        reset = 1'b1;
        step();
        check_val("inflight_b_0", {31'd0, rd_valid_b}, 32'd0);
        check_val("inflight_d_0", {31'd0, rd_valid_d}, 32'd0);
        check_val("rst_busy_d2", {31'd0, busy_d}, 32'd0);
        reset = 1'b0;
        step();
        check_val("inflight_b_1", {31'd0, rd_valid_b}, 32'd0);
        check_val("inflight_d_1", {31'd0, rd_valid_d}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_sdp_param.md
# mem_sdp_param

Parametrised simple-dual-port synchronous RAM: the next generation of the fixed 64 × 32-bit single-port memory used across the datapath. It has one write port and one independent read port, per-byte write enables, 1- or 2-cycle read latency with a `rd_valid` qualifier, and selectable read-during-write behaviour. An optional post-reset clear sequencer zeroes the array. Buffers and scratchpads in the PE array instantiate it wherever the 256 B single-port block is too narrow, too shallow or too slow.

## Interface
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 64: number of words; need not be a power of two.
- `ADDR_W`, `$clog2(DEPTH)`: address width; derived, do not override.
- `RD_LAT`, 1: read latency in cycles; 1 or 2 only. Any other value is an elaboration error.
- `RDW_MODE`, 0: same-address read during write. 0 = read-old, 1 = write-through.
- `CLEAR_ON_RESET`, 1: 1 = zero the whole array after reset; 0 = contents undefined after reset.
- `clk` in 1: clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: write request.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `wr_be` in DATA_W/8: byte enables; bit i covers `wr_data[8i+7:8i]`.
- `rd_en` in 1: read request.
- `rd_addr` in ADDR_W: read address.
- `rd_data` out DATA_W: read data; 0 whenever `rd_valid` = 0.
- `rd_valid` out 1: `rd_data` carries the result of a read.
- `busy` out 1: clear sequence in progress; all requests are ignored while it is high.

## Operation
- **Reset values:** `rd_data` = 0, `rd_valid` = 0, all pipeline stages = 0. `busy` = `CLEAR_ON_RESET` while `reset` is high.
- **FSM (only when CLEAR_ON_RESET = 1):** states IDLE and CLEAR.
  - `reset` forces CLEAR with the clear counter at 0.
  - In CLEAR, each cycle writes all-zero to `mem[cnt]` and increments `cnt`.
  - After writing `DEPTH-1`, the FSM moves to IDLE.
  - `busy` = (state == CLEAR).
  - Reset asserted mid-clear restarts the sequence at address 0.
- **Behaviour while busy:**
  - `wr_en` is dropped and the array is not modified by the user port.
  - `rd_en` is dropped; `rd_valid` stays 0.
  - Requests are not queued.
- **Write:** when `wr_en` is high, not busy, and `wr_addr < DEPTH`, byte i of `mem[wr_addr]` is updated iff `wr_be[i]`.
  - `wr_be` = 0 is a legal no-op.
  - `wr_addr >= DEPTH` is ignored silently.
- **Read:** when `rd_en` is high and not busy, the port returns `mem[rd_addr]`.
  - `rd_addr >= DEPTH` returns 0, with `rd_valid` still asserted.
  - When there is no read, `rd_data` returns to 0 on the next edge. This matches the legacy block's zero-when-idle output.
- **Read-during-write** (same cycle, same in-range address, both enabled):
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the merged word, i.e. new bytes where `wr_be` = 1 and old bytes elsewhere.
  - Different addresses never interact.
- Reads and writes are fully independent and may both fire every cycle. Throughput is one read and one write per cycle.

## Timing
- **RD_LAT = 1:** with `rd_en` sampled at edge N, `rd_data`/`rd_valid` are valid after edge N (visible during cycle N+1).
- **RD_LAT = 2:** one more registered stage, so valid after edge N+1. The stage also carries `rd_valid`; back-to-back reads pipeline without bubbles.
- Write data is visible to a read sampled at the next edge after the write, in either mode.
- **Clear duration:** `busy` stays high during reset and for exactly DEPTH cycles after the first edge with `reset` low. The first accepted request is on the edge following the final clear write.
- Reset clears in-flight read pipeline stages. No `rd_valid` pulse appears for a read issued before reset.

## Test plan
- **Clear sequence** (DEPTH = 64, CLEAR_ON_RESET = 1):
  - Stimulus: release reset, then read all addresses after `busy` falls.
  - Required: `busy` high for 64 cycles and every read returns 0x00000000 with `rd_valid` = 1.
  - Also: a write to 5 issued while busy leaves `mem[5]` = 0.
- **Byte enables:**
  - Stimulus: write 0xAABBCCDD to address 3 with be = 4'b1111, then 0x11223344 with be = 4'b0101.
  - Required: read returns 0xAA22CC44.
- **Read-during-write:**
  - Preload address 7 with 0x12345678, then same cycle write 0xFFFFFFFF (be = 4'b0011) and read 7.
  - RDW_MODE = 0: returns 0x12345678.
  - RDW_MODE = 1: returns 0x1234FFFF.
- **Latency and streaming:**
  - Stimulus: RD_LAT = 2, reads of addresses 0..3 on consecutive cycles.
  - Required: `rd_valid` high for 4 consecutive cycles starting 2 edges after the first request, and data in order.
  - Required: `rd_data` = 0 on the cycle after the stream ends.
- **Non-power-of-two depth** (DEPTH = 48):
  - Write address 50.
  - Required: no array change (spot-check addresses 50 mod 32 = 18 and 47 unchanged).
  - Required: a read of 50 returns 0 with `rd_valid` = 1.
- **Reset mid-operation:**
  - Stimulus: assert reset at clear count 20, hold 1 cycle.
  - Required: `busy` lasts a further 64 cycles after release.
  - Stimulus: assert reset while an RD_LAT = 2 read is in flight.
  - Required: no `rd_valid` pulse.
